mux8way_arbiter: RTL and testbench
==================================

Name: mux8way_arbiter

Overview:
- Gathering counterpart of the 8-way demultiplexer in the hack_soc fabric.
- Merges eight independent valid/ready sources of D_WIDTH data into one registered output stream.
- Uses a round-robin grant and tags each beat with its 3-bit source index; the index uses the same encoding as the demux select.
- Used wherever several producers (e.g. peripheral return paths) must share one bus toward the CPU side.

Parameters:
D_WIDTH, 16, data width per source and of the output (Hack word)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  8  bit i = source i presents a beat
in_data  input  8*D_WIDTH  packed source data; source i occupies bits [i*D_WIDTH +: D_WIDTH]
in_ready  output  8  one-hot (or zero) accept strobe; bit i = source i's beat is taken this cycle
out_valid  output  1  output register holds a beat
out_data  output  D_WIDTH  registered data of held beat
out_sel  output  3  index of source that produced held beat (000 = source 0 ... 111 = source 7)
out_ready  input  1  downstream accepts held beat this cycle

Behaviour:
- Reset (reset_n low at a clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer last=7, so source 0 has highest priority first.
  - in_ready is forced to all zeros while reset_n is low.
- Any held beat is discarded on reset, including mid-transfer. Sources must not count an unacknowledged beat as sent.
- can_accept = !out_valid | out_ready (combinational).
- Grant:
  - Search in_valid starting at index (last+1) mod 8, wrapping 7->0.
  - The first set bit is the winner g.
  - in_ready = can_accept ? onehot(g) : 0. If in_valid==0, in_ready=0.
  - in_ready is combinational from in_valid, out_valid, out_ready and last.
- Transfer (in_valid[g] & in_ready[g]) at a clock edge:
  - out_data <= in_data slice g.
  - out_sel <= g.
  - out_valid <= 1.
  - last <= g.
- Latency is 1 cycle from transfer to out_valid high.
- Drain without refill (out_valid & out_ready, no transfer): out_valid <= 0. out_data and out_sel keep their values.
- Simultaneous drain and transfer in one cycle: the new beat replaces the old. out_valid stays 1. Throughput is 1 beat/cycle.
- Stall (out_valid & !out_ready):
  - in_ready=0.
  - out_data, out_sel and out_valid stay stable until accepted.
  - last does not change.
- last changes only on transfer. An idle cycle does not rotate priority.
- A source may drop in_valid without being granted, and a source may raise it in any cycle. The arbiter places no requirement on either.
- Fairness: with all 8 valid continuously and out_ready=1, grants cycle 0,1,...,7,0,... Any continuously requesting source is served within 8 transfers.
- No combinational path from out_ready to out_valid/out_data/out_sel.

Test Plan:
1. Reset then all in_valid=0 for 5 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=00000000 throughout.
2. After reset, in_valid=8'hFF, source i data=16'h1000+i, out_ready=1 for 10 cycles -> out_sel sequence 0,1,...,7,0,1 starting 1 cycle after first grant; out_data=16'h1000+out_sel each beat; exactly one in_ready bit high per cycle.
3. Only sources 2 and 5 valid, out_ready=1 -> grants alternate 2,5,2,5. Then drop source 5 -> source 2 is granted every cycle.
4. Beat from source 3 (data 16'hBEEF) held, out_ready=0 for 4 cycles while source 6 valid -> out_data=16'hBEEF, out_sel=3, in_ready=0 for all 4 cycles. On the out_ready=1 cycle, in_ready[6]=1 and the next cycle shows out_sel=6.
5. Single beat from source 7, then out_ready=1 with no valids -> out_valid falls next cycle. Then source 0 and source 7 both valid -> source 0 wins (pointer 7, search from 0).
6. Beat held with out_ready=0, then reset_n=0 for one edge -> out_valid=0, out_data=0, out_sel=0, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/mux8way_arbiter_if.sv
// Bus bundle for the 8-way round-robin gathering arbiter: eight valid/ready
// source lanes on the input side, one registered tagged stream on the output.
interface mux8way_arbiter_if #(
  parameter int D_WIDTH = 16
);
  logic [7:0]           in_valid;
  logic [8*D_WIDTH-1:0] in_data;
  logic [7:0]           in_ready;
  logic                 out_valid;
  logic [D_WIDTH-1:0]   out_data;
  logic [2:0]           out_sel;
  logic                 out_ready;

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux8way_arbiter.sv
// Merges eight valid/ready sources into one registered stream using a
// round-robin grant; each beat is tagged with its 3-bit source index.
module mux8way_arbiter #(
  parameter int D_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mux8way_arbiter_if.slave  bus
);

  logic [2:0]         r_last;
  logic               r_out_valid;
  logic [D_WIDTH-1:0] r_out_data;
  logic [2:0]         r_out_sel;

  logic               w_can_accept;
  logic               w_found;
  logic [2:0]         w_grant_idx;
  logic [2:0]         w_cand;
  logic [D_WIDTH-1:0] w_grant_data;
  logic               w_transfer;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_can_accept = !r_out_valid || bus.out_ready;

  // Round-robin search starting one past the last winner, wrapping 7 -> 0.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_found     = 1'b0;
    w_grant_idx = 3'd0;
    w_cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_last + 3'd1 + 3'(k);
      if (!w_found && bus.in_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_grant_idx == 3'(k)) begin
        w_grant_data = bus.in_data[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign w_transfer   = reset_n && w_can_accept && w_found;
  assign bus.in_ready = w_transfer ? (8'b1 << w_grant_idx) : 8'b0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 3'd0;
      r_last      <= 3'd7;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_sel   <= w_grant_idx;
      r_last      <= w_grant_idx;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Directed bench for mux8way_arbiter: stimulus pushes expected beats into a
// scoreboard queue, a monitor pops and compares each beat the DUT delivers.
module tb_mux8way_arbiter;

  localparam int D_WIDTH = 16;

  typedef struct packed {
    logic [2:0]         sel;
    logic [D_WIDTH-1:0] data;
  } beat_t;

  logic clk;
  logic reset_n;
  logic [D_WIDTH-1:0] src_data [8];
  beat_t sb [$];
  int n_cmp = 0;
  int n_err = 0;

  mux8way_arbiter_if #(.D_WIDTH(D_WIDTH)) bus ();

  mux8way_arbiter #(.D_WIDTH(D_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) bus.in_data[i*D_WIDTH +: D_WIDTH] = src_data[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat is accepted at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected beat (queue empty)", 32'(bus.out_sel), 32'hFFFF_FFFF);
      end else begin
        beat_t exp_b;
        exp_b = sb.pop_front();
        check("mon out_sel",  32'(bus.out_sel),  32'(exp_b.sel));
        check("mon out_data", 32'(bus.out_data), 32'(exp_b.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic rdy);
    bus.in_valid  = v;
    bus.out_ready = rdy;
    #1;
  endtask

  // One cycle with a hand-computed winner g (-1 = no grant expected).
  task automatic grant_cycle(input logic [7:0] v, input logic rdy, input int g, input string tag);
    logic [7:0] exp_rdy;
    beat_t b;
    drive(v, rdy);
    exp_rdy = (g < 0) ? 8'h00 : (8'h01 << g);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if (g >= 0) begin
      b.sel  = 3'(g);
      b.data = src_data[g];
      sb.push_back(b);
    end
    cyc();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] s, input logic [D_WIDTH-1:0] d);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, " out_sel"},   32'(bus.out_sel),   32'(s));
    check({tag, " out_data"},  32'(bus.out_data),  32'(d));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) src_data[i] = 16'h1000 + 16'(i);
    reset_n       = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset: in_ready forced low even with every source requesting.
    cyc();
    check("reset in_ready", 32'(bus.in_ready), 32'h0);
    check_out("reset", 1'b0, 3'd0, 16'h0);
    cyc();
    reset_n = 1'b1;

    // Test 1: idle after reset.
    for (int c = 0; c < 5; c++) begin
      drive(8'h00, 1'b1);
      check("t1 in_ready", 32'(bus.in_ready), 32'h0);
      check_out("t1", 1'b0, 3'd0, 16'h0);
      cyc();
    end

    // Test 2: all sources valid -> 0..7,0,1.
    for (int c = 0; c < 10; c++) grant_cycle(8'hFF, 1'b1, c % 8, "t2");
    grant_cycle(8'h00, 1'b1, -1, "t2 drain");
    check("t2 drained out_valid", 32'(bus.out_valid), 32'h0);

    // Test 3: sources 2 and 5 alternate; then source 2 alone (last=1 now).
    grant_cycle(8'h24, 1'b1, 2, "t3 a");
    grant_cycle(8'h24, 1'b1, 5, "t3 b");
    grant_cycle(8'h24, 1'b1, 2, "t3 c");
    grant_cycle(8'h24, 1'b1, 5, "t3 d");
    for (int c = 0; c < 3; c++) grant_cycle(8'h04, 1'b1, 2, "t3 solo");
    grant_cycle(8'h00, 1'b1, -1, "t3 drain");

    // Test 4: beat from source 3 stalled for 4 cycles while source 6 waits.
    src_data[3] = 16'hBEEF;
    grant_cycle(8'h08, 1'b1, 3, "t4 grant3");
    for (int c = 0; c < 4; c++) begin
      drive(8'h40, 1'b0);
      check("t4 stall in_ready", 32'(bus.in_ready), 32'h0);
      check_out("t4 stall", 1'b1, 3'd3, 16'hBEEF);
      cyc();
    end
    grant_cycle(8'h40, 1'b1, 6, "t4 grant6");
    check_out("t4 after", 1'b1, 3'd6, 16'h1006);
    grant_cycle(8'h00, 1'b1, -1, "t4 drain");

    // Test 5: single beat from 7 drains, then 0 beats 7 (pointer at 7).
    grant_cycle(8'h80, 1'b1, 7, "t5 grant7");
    drive(8'h00, 1'b1);
    check("t5 idle in_ready", 32'(bus.in_ready), 32'h0);
    check_out("t5 held", 1'b1, 3'd7, 16'h1007);
    cyc();
    check_out("t5 drained", 1'b0, 3'd7, 16'h1007);
    grant_cycle(8'h81, 1'b1, 0, "t5 0vs7");
    grant_cycle(8'h00, 1'b1, -1, "t5 drain");

    // Test 6: reset mid-transfer discards the held beat and resets the pointer.
    grant_cycle(8'h10, 1'b1, 4, "t6 grant4");
    drive(8'h00, 1'b0);
    cyc();
    check_out("t6 held", 1'b1, 3'd4, 16'h1004);
    reset_n = 1'b0;
    drive(8'h22, 1'b0);
    check("t6 reset in_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    reset_n = 1'b1;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    check_out("t6 reset", 1'b0, 3'd0, 16'h0);
    grant_cycle(8'h22, 1'b1, 1, "t6 lowest");
    check_out("t6 after", 1'b1, 3'd1, 16'h1001);
    grant_cycle(8'h00, 1'b1, -1, "t6 drain");

    cyc();
    cyc();
    check("scoreboard empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
